bg_pixel_pipeline: RTL and testbench

- Background render stage that feeds the background frame RAM and consumes its output.
- Converts VGA pixel coordinates into a RAM read address, waits out the RAM's 1-cycle read latency, and maps the returned palette index to 24-bit RGB through a double-buffered palette.
- Sits between the VGA controller (DrawX/DrawY, blanking) and the colour output; palette updates become visible only at frame boundaries, so there is no tearing.

---
 rtl/bg_pkg.sv | 33 +++
 rtl/bg_pixel_pipeline_palette.sv | 93 +++++++++
 rtl/bg_pixel_pipeline.sv | 133 +++++++++++++
 tb/tb_bg_pixel_pipeline.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bg_pkg.sv
// -----------------------------------------------------------------------------
// bg_pkg
// Shared types and constants for the background pixel pipeline.
//   rgb_t        : packed {r, g, b} colour, 8 bits per channel
//   BORDER_RGB   : colour shown for visible pixels outside the source image
//   PAL_ENTRIES  : physical palette depth, matching the 3-bit write index
//   pal_state_t  : palette commit FSM states
//   default_pal  : reset contents of both palettes, a grey ramp i*36
// -----------------------------------------------------------------------------
package bg_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t BORDER_RGB  = 24'h202020;
  localparam int   PAL_ENTRIES = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } pal_state_t;

  // Grey ramp: entry i = {i*36, i*36, i*36}; 7*36 = 252 still fits 8 bits.
  function automatic rgb_t default_pal(input int unsigned idx);
    logic [7:0] v;
    v = 8'(idx * 36);
    return '{r: v, g: v, b: v};
  endfunction

endpackage

// File: rtl/bg_pixel_pipeline_palette.sv
// -----------------------------------------------------------------------------
// bg_palette
// Double-buffered palette. Writes always land in the shadow copy; the active
// copy (the one the pixel path reads) is refreshed from the shadow only when a
// commit meets a frame_tick, so colour changes never tear mid-frame.
// Ports:
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_we, i_wr_idx,
//   i_wr_rgb            : shadow write port
//   i_commit            : request a shadow-to-active copy at the next tick
//   i_frame_tick        : once-per-frame pulse in vertical blanking
//   i_rd_idx, o_rd_rgb  : combinational read of the active palette
//   o_busy              : a commit is waiting for its frame_tick
//   o_commit_done       : one-cycle pulse, high in the cycle after the copy
// -----------------------------------------------------------------------------
module bg_palette
  import bg_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [2:0]  i_wr_idx,
  input  logic [23:0] i_wr_rgb,
  input  logic        i_commit,
  input  logic        i_frame_tick,
  input  logic [2:0]  i_rd_idx,
  output logic [23:0] o_rd_rgb,
  output logic        o_busy,
  output logic        o_commit_done
);

  rgb_t       r_shadow [PAL_ENTRIES];
  rgb_t       r_active [PAL_ENTRIES];
  pal_state_t r_state;
  logic       r_busy;
  logic       r_commit_done;
  logic       w_copy;

  // A commit fires on a tick either when one is already pending or when the
  // request and the tick arrive together while idle.
  assign w_copy = ((r_state == PENDING) || i_commit) && i_frame_tick;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: these arrays are reset on purpose: both palettes must come up
      // holding the default ramp, so they are flops, not an inferred RAM.
      for (int i = 0; i < PAL_ENTRIES; i++) begin
        r_shadow[i] <= default_pal(i);
        r_active[i] <= default_pal(i);
      end
      r_state       <= IDLE;
      r_busy        <= 1'b0;
      r_commit_done <= 1'b0;
    end else begin
      r_commit_done <= w_copy;

      case (r_state)
        IDLE: begin
          if (i_commit && !i_frame_tick) begin
            r_state <= PENDING;
            r_busy  <= 1'b1;
          end
        end
        PENDING: begin
          // Further commits while pending are absorbed.
          if (i_frame_tick) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // NOTE: non-blocking assignment means the copy below reads the shadow
      // as it stood before this edge, so a same-cycle write reaches only the
      // shadow and waits for the next commit.
      if (w_copy) begin
        r_active <= r_shadow;
      end
      if (i_we) begin
        r_shadow[i_wr_idx] <= i_wr_rgb;
      end
    end
  end

  assign o_rd_rgb      = r_active[i_rd_idx];
  assign o_busy        = r_busy;
  assign o_commit_done = r_commit_done;

endmodule

// File: rtl/bg_pixel_pipeline.sv
// -----------------------------------------------------------------------------
// bg_pixel_pipeline
// Background render stage. Scales VGA coordinates down to source pixels,
// addresses the frame RAM, waits out its one-cycle read latency and maps the
// returned palette index to RGB. Three cycles from DrawX/DrawY to colour,
// one pixel per cycle, no stalls.
//   S1: coordinate -> read_address, register visible / in-image flags
//   S2: RAM read in flight, flags delayed one more cycle
//   S3: colour select and output register
// Ports:
//   Clk, Reset                      : pixel clock, async active-high reset
//   DrawX, DrawY, visible           : VGA controller position and blanking
//   frame_tick                      : once-per-frame pulse (vertical blank)
//   read_address, ram_data          : frame RAM address out / index in
//   pal_we, pal_wr_idx, pal_wr_rgb  : shadow palette write port
//   pal_commit, pal_busy,
//   commit_done                     : palette commit handshake
//   Red, Green, Blue, rgb_valid     : registered pixel colour
// -----------------------------------------------------------------------------
module bg_pixel_pipeline
  import bg_pkg::*;
#(
  parameter int IMG_W       = 20,
  parameter int IMG_H       = 20,
  parameter int SCALE_SHIFT = 4,
  parameter int ADDR_W      = 19,
  parameter int IDX_W       = 5,
  parameter int PAL_SIZE    = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              visible,
  input  logic              frame_tick,
  output logic [ADDR_W-1:0] read_address,
  input  logic [IDX_W-1:0]  ram_data,
  input  logic              pal_we,
  input  logic [2:0]        pal_wr_idx,
  input  logic [23:0]       pal_wr_rgb,
  input  logic              pal_commit,
  output logic              pal_busy,
  output logic              commit_done,
  output logic [7:0]        Red,
  output logic [7:0]        Green,
  output logic [7:0]        Blue,
  output logic              rgb_valid
);

  localparam logic [9:0]       IMG_W_L   = 10'(IMG_W);
  localparam logic [9:0]       IMG_H_L   = 10'(IMG_H);
  localparam logic [IDX_W-1:0] PAL_LIMIT = IDX_W'(PAL_SIZE);

  // S1 combinational
  logic [9:0]        w_sx;
  logic [9:0]        w_sy;
  logic              w_in_img;
  logic [ADDR_W-1:0] w_addr;

  // Pipeline registers
  logic [ADDR_W-1:0] r_read_address;
  logic              r_vis1;
  logic              r_in1;
  logic              r_vis2;
  logic              r_in2;
  rgb_t              r_rgb;
  logic              r_rgb_valid;

  // S3 combinational
  rgb_t              w_pal_rgb;
  rgb_t              w_pix_rgb;

  assign w_sx     = DrawX >> SCALE_SHIFT;
  assign w_sy     = DrawY >> SCALE_SHIFT;
  assign w_in_img = (w_sx < IMG_W_L) && (w_sy < IMG_H_L);
  // Outside the image the address is parked at 0; the data is ignored in S3.
  assign w_addr   = w_in_img ? (ADDR_W'(w_sy) * ADDR_W'(IMG_W) + ADDR_W'(w_sx))
                             : '0;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_read_address <= '0;
      r_vis1         <= 1'b0;
      r_in1          <= 1'b0;
      r_vis2         <= 1'b0;
      r_in2          <= 1'b0;
      r_rgb          <= '0;
      r_rgb_valid    <= 1'b0;
    end else begin
      r_read_address <= w_addr;
      r_vis1         <= visible;
      r_in1          <= w_in_img;
      r_vis2         <= r_vis1;
      r_in2          <= r_in1;
      r_rgb          <= w_pix_rgb;
      r_rgb_valid    <= r_vis2;
    end
  end

  bg_palette u_palette (
    .i_clk         (Clk),
    .i_rst         (Reset),
    .i_we          (pal_we),
    .i_wr_idx      (pal_wr_idx),
    .i_wr_rgb      (pal_wr_rgb),
    .i_commit      (pal_commit),
    .i_frame_tick  (frame_tick),
    .i_rd_idx      (ram_data[2:0]),
    .o_rd_rgb      (w_pal_rgb),
    .o_busy        (pal_busy),
    .o_commit_done (commit_done)
  );

  always_comb begin
    // NOTE: default first so every path assigns w_pix_rgb and no latch forms.
    w_pix_rgb = '0;
    if (r_vis2) begin
      if (!r_in2) begin
        w_pix_rgb = BORDER_RGB;
      end else if (ram_data < PAL_LIMIT) begin
        // Out-of-range indices stay black.
        w_pix_rgb = w_pal_rgb;
      end
    end
  end

  assign read_address = r_read_address;
  assign Red          = r_rgb.r;
  assign Green        = r_rgb.g;
  assign Blue         = r_rgb.b;
  assign rgb_valid    = r_rgb_valid;

endmodule

// File: tb/tb_bg_pixel_pipeline.sv
// -----------------------------------------------------------------------------
// tb_bg_pixel_pipeline
// Drives bg_pixel_pipeline with directed scenarios followed by random pixels
// and palette traffic. A frame RAM model answers read_address one cycle late.
// A reference model predicts each output from the pixel coordinates, the RAM
// image and a shadow/active palette pair with a pending-commit flag.
// -----------------------------------------------------------------------------
module tb_bg_pixel_pipeline;

  localparam int          IMG_W   = 20;
  localparam int          IMG_H   = 20;
  localparam int          SCALE   = 16;
  localparam int          PAL_N   = 8;
  localparam logic [23:0] BORDER  = 24'h202020;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        visible = 1'b0;
  logic        frame_tick = 1'b0;
  logic [18:0] read_address;
  logic [4:0]  ram_data = '0;
  logic        pal_we = 1'b0;
  logic [2:0]  pal_wr_idx = '0;
  logic [23:0] pal_wr_rgb = '0;
  logic        pal_commit = 1'b0;
  logic        pal_busy;
  logic        commit_done;
  logic [7:0]  Red, Green, Blue;
  logic        rgb_valid;

  int n_tests = 0;
  int n_fail  = 0;

  bg_pixel_pipeline dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .visible      (visible),
    .frame_tick   (frame_tick),
    .read_address (read_address),
    .ram_data     (ram_data),
    .pal_we       (pal_we),
    .pal_wr_idx   (pal_wr_idx),
    .pal_wr_rgb   (pal_wr_rgb),
    .pal_commit   (pal_commit),
    .pal_busy     (pal_busy),
    .commit_done  (commit_done),
    .Red          (Red),
    .Green        (Green),
    .Blue         (Blue),
    .rgb_valid    (rgb_valid)
  );

  always #5 Clk = ~Clk;

  // Frame RAM: synchronous read, data valid one cycle after the address.
  logic [4:0] mem [0:511];
  always @(posedge Clk) begin
    ram_data <= (read_address < 19'd400) ? mem[read_address[8:0]] : 5'd0;
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [23:0] m_shadow [PAL_N];
  logic [23:0] m_active [PAL_N];
  logic        m_pending;
  logic        d1_vis, d1_in, d2_vis, d2_in;
  int          d1_addr, d2_addr;
  int          exp_addr;
  logic [23:0] exp_rgb;
  logic        exp_valid, exp_busy, exp_done;

  function automatic logic [23:0] grey(input int i);
    logic [7:0] v;
    v = 8'(i * 36);
    return {v, v, v};
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < PAL_N; i++) begin
        m_shadow[i] = grey(i);
        m_active[i] = grey(i);
      end
      m_pending = 1'b0;
      d1_vis = 1'b0; d1_in = 1'b0; d1_addr = 0;
      d2_vis = 1'b0; d2_in = 1'b0; d2_addr = 0;
      exp_addr = 0; exp_rgb = '0; exp_valid = 1'b0;
      exp_busy = 1'b0; exp_done = 1'b0;
    end else begin
      int  sx, sy, idx;
      logic fire;
      // Colour for the pixel sampled two edges ago, using the palette as it
      // stands before this edge's copy.
      exp_valid = d2_vis;
      if (!d2_vis)      exp_rgb = '0;
      else if (!d2_in)  exp_rgb = BORDER;
      else begin
        idx = int'(mem[d2_addr]);
        exp_rgb = (idx < PAL_N) ? m_active[idx] : 24'h0;
      end
      d2_vis = d1_vis; d2_in = d1_in; d2_addr = d1_addr;
      sx = int'(DrawX) / SCALE;
      sy = int'(DrawY) / SCALE;
      d1_vis  = visible;
      d1_in   = (sx < IMG_W) && (sy < IMG_H);
      d1_addr = d1_in ? sy * IMG_W + sx : 0;
      exp_addr = d1_addr;

      fire = (m_pending || pal_commit) && frame_tick;
      exp_done = fire;
      if (fire) begin
        m_active  = m_shadow;
        m_pending = 1'b0;
      end else if (pal_commit) begin
        m_pending = 1'b1;
      end
      exp_busy = m_pending;
      if (pal_we) m_shadow[pal_wr_idx] = pal_wr_rgb;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking and stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic chk_en = 1'b0;

  // Advance one clock, compare every output with the model, clear pulses.
  task automatic step();
    @(negedge Clk);
    if (chk_en && !Reset) begin
      check("addr",  32'(read_address), 32'(exp_addr));
      check("rgb",   {8'h0, Red, Green, Blue}, {8'h0, exp_rgb});
      check("valid", 32'(rgb_valid), 32'(exp_valid));
      check("busy",  32'(pal_busy), 32'(exp_busy));
      check("done",  32'(commit_done), 32'(exp_done));
    end
    pal_we     = 1'b0;
    pal_commit = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic pix(input logic v, input int x, input int y);
    visible = v;
    DrawX   = 10'(x);
    DrawY   = 10'(y);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [31:0] rgb32();
    return {8'h0, Red, Green, Blue};
  endfunction

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 5'($urandom_range(0, 11));
    mem[22] = 5'd3;   // (37,18)  -> source (2,1)
    mem[23] = 5'd5;   // (48,16)  -> source (3,1)
    mem[41] = 5'd9;   // (16,32)  -> source (1,2), out-of-range index

    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_addr",  32'(read_address), 32'd0);
    check("rst_rgb",   rgb32(), 32'd0);
    check("rst_valid", 32'(rgb_valid), 32'd0);
    check("rst_busy",  32'(pal_busy), 32'd0);
    check("rst_done",  32'(commit_done), 32'd0);
    Reset  = 1'b0;
    chk_en = 1'b1;

    // In-image pixel, index 3 -> default grey 108.
    pix(1'b1, 37, 18); step();
    check("t1_addr", 32'(read_address), 32'd22);
    pix(1'b0, 0, 0); steps(2);
    check("t1_rgb",   rgb32(), 32'h006C6C6C);
    check("t1_valid", 32'(rgb_valid), 32'd1);

    // Right of the image -> border colour.
    pix(1'b1, 320, 0); step();
    check("t2_addr", 32'(read_address), 32'd0);
    pix(1'b0, 0, 0); steps(2);
    check("t2_rgb",   rgb32(), 32'h00202020);
    check("t2_valid", 32'(rgb_valid), 32'd1);

    // Blanked pixel.
    pix(1'b0, 37, 18); steps(3);
    check("t3_rgb",   rgb32(), 32'd0);
    check("t3_valid", 32'(rgb_valid), 32'd0);

    // Index 9 is beyond the palette -> black but valid.
    pix(1'b1, 16, 32); step(); pix(1'b0, 0, 0); steps(2);
    check("t4_rgb",   rgb32(), 32'd0);
    check("t4_valid", 32'(rgb_valid), 32'd1);

    // Commit waits for frame_tick.
    pix(1'b1, 37, 18);
    pal_we = 1'b1; pal_wr_idx = 3'd3; pal_wr_rgb = 24'hFF0000; pal_commit = 1'b1;
    steps(101);
    check("t5_hold_rgb", rgb32(), 32'h006C6C6C);
    check("t5_busy",     32'(pal_busy), 32'd1);
    frame_tick = 1'b1; step();
    check("t5_done", 32'(commit_done), 32'd1);
    check("t5_idle", 32'(pal_busy), 32'd0);
    step();
    check("t5_done_once", 32'(commit_done), 32'd0);
    check("t5_new_rgb",   rgb32(), 32'h00FF0000);

    // Immediate commit with a same-cycle shadow write to index 5.
    pix(1'b1, 48, 16);
    pal_we = 1'b1; pal_wr_idx = 3'd5; pal_wr_rgb = 24'h00FF00;
    pal_commit = 1'b1; frame_tick = 1'b1;
    step();
    check("t6_done", 32'(commit_done), 32'd1);
    check("t6_busy", 32'(pal_busy), 32'd0);
    steps(3);
    check("t6_active5", rgb32(), 32'h00B4B4B4);
    // A second commit exposes the shadow write.
    pal_commit = 1'b1; frame_tick = 1'b1; steps(2);
    check("t6_shadow5", rgb32(), 32'h0000FF00);

    // Reset while pending drops the commit and restores defaults.
    pal_commit = 1'b1; steps(2);
    check("t7_pending", 32'(pal_busy), 32'd1);
    Reset = 1'b1;
    #1;
    check("t7_rst_busy", 32'(pal_busy), 32'd0);
    check("t7_rst_rgb",  rgb32(), 32'd0);
    step();
    Reset = 1'b0;
    pix(1'b1, 48, 16); pal_commit = 1'b1; frame_tick = 1'b1; steps(3);
    check("t7_default5", rgb32(), 32'h00B4B4B4);
    pix(1'b1, 37, 18); steps(3);
    check("t7_default3", rgb32(), 32'h006C6C6C);

    // Random pixels and palette traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      pix(($urandom_range(0, 3) != 0), $urandom_range(0, 399),
          $urandom_range(0, 399));
      pal_we     = ($urandom_range(0, 3) == 0);
      pal_wr_idx = 3'($urandom_range(0, 7));
      pal_wr_rgb = 24'($urandom);
      pal_commit = ($urandom_range(0, 29) == 0);
      frame_tick = ($urandom_range(0, 49) == 0);
      if (i == 1500) begin
        Reset = 1'b1;
        step();
        Reset = 1'b0;
      end else begin
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
